// File: rtl/button_debounce_conditioner.sv
// Conditions one raw push-button into a debounced level with press/release one-shots,
// long-press detection and auto-repeat ticks, all in the button PIO clock domain.
module button_debounce_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int REPEAT_CYCLES     = 10000000,
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int CNT_W             = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_raw,
  input  logic enable,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  localparam logic             IDLE_LVL = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] REP_C    = CNT_W'(REPEAT_CYCLES);
  localparam bit               DB_ONE   = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    RELEASED,
    CONFIRM_PRESS,
    PRESSED,
    CONFIRM_RELEASE
  } state_t;

  state_t           state, state_nxt;
  logic             sync1, sync2, pressed;
  logic [CNT_W-1:0] db_cnt, db_nxt, db_inc;
  logic [CNT_W-1:0] hold_cnt, hold_nxt, hold_inc;
  logic             level_nxt, press_nxt, release_nxt, long_nxt, repeat_nxt;

  // Synchroniser idles at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE_LVL;
      sync2 <= IDLE_LVL;
    end else begin
      sync1 <= button_raw;
      sync2 <= sync1;
    end
  end

  assign pressed  = sync2 ^ IDLE_LVL;
  assign db_inc   = (db_cnt == CNT_MAX) ? db_cnt : db_cnt + ONE;
  assign hold_inc = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RELEASED;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_nxt;
      db_cnt        <= db_nxt;
      hold_cnt      <= hold_nxt;
      btn_level     <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_press    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    db_nxt      = db_cnt;
    hold_nxt    = hold_cnt;
    level_nxt   = btn_level;
    long_nxt    = long_press;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    repeat_nxt  = 1'b0;
    if (!enable) begin
      state_nxt = RELEASED;
      db_nxt    = '0;
      hold_nxt  = '0;
      level_nxt = 1'b0;
      long_nxt  = 1'b0;
    end else begin
      case (state)
        RELEASED: begin
          db_nxt    = '0;
          level_nxt = 1'b0;
          if (pressed) begin
            if (DB_ONE) begin
              state_nxt = PRESSED;
              level_nxt = 1'b1;
              press_nxt = 1'b1;
              hold_nxt  = '0;
              long_nxt  = 1'b0;
            end else begin
              db_nxt    = ONE;
              state_nxt = CONFIRM_PRESS;
            end
          end
        end
        CONFIRM_PRESS: begin
          if (!pressed) begin
            state_nxt = RELEASED;
            db_nxt    = '0;
          end else if (db_cnt >= DB_LAST) begin
            state_nxt = PRESSED;
            db_nxt    = '0;
            level_nxt = 1'b1;
            press_nxt = 1'b1;
            hold_nxt  = '0;
            long_nxt  = 1'b0;
          end else begin
            db_nxt = db_inc;
          end
        end
        PRESSED: begin
          // hold_cnt times the long-press delay, then restarts as the repeat timer.
          if (!pressed) begin
            if (DB_ONE) begin
              state_nxt   = RELEASED;
              db_nxt      = '0;
              hold_nxt    = '0;
              level_nxt   = 1'b0;
              long_nxt    = 1'b0;
              release_nxt = 1'b1;
            end else begin
              db_nxt    = ONE;
              state_nxt = CONFIRM_RELEASE;
            end
          end else if (!long_press) begin
            if (hold_inc >= LONG_C) begin
              long_nxt = 1'b1;
              hold_nxt = '0;
            end else begin
              hold_nxt = hold_inc;
            end
          end else if (hold_inc >= REP_C) begin
            repeat_nxt = 1'b1;
            hold_nxt   = '0;
          end else begin
            hold_nxt = hold_inc;
          end
        end
        CONFIRM_RELEASE: begin
          if (pressed) begin
            state_nxt = PRESSED;
            db_nxt    = '0;
          end else if (db_cnt >= DB_LAST) begin
            state_nxt   = RELEASED;
            db_nxt      = '0;
            hold_nxt    = '0;
            level_nxt   = 1'b0;
            long_nxt    = 1'b0;
            release_nxt = 1'b1;
          end else begin
            db_nxt = db_inc;
          end
        end
        default: begin
          state_nxt = RELEASED;
          db_nxt    = '0;
          hold_nxt  = '0;
          level_nxt = 1'b0;
          long_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce_conditioner.sv
// Randomised and directed bench for button_debounce_conditioner against a
// run-length based reference model of the debounce/hold/repeat rules.
module tb_button_debounce_conditioner;

  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;

  logic clk = 1'b0;
  logic reset_n, button_raw, enable;
  logic btn_level, press_pulse, release_pulse, long_press, repeat_pulse;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: sync pipe, committed level, run of contrary samples, pressed-hold time.
  int m_s1, m_s2, m_commit, m_run, m_held, m_lp, m_press, m_rel, m_rep;

  button_debounce_conditioner #(
    .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LONG), .REPEAT_CYCLES(REP),
    .ACTIVE_LOW(1'b1), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .button_raw(button_raw), .enable(enable),
    .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_press(long_press), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1; m_s2 = 1; m_commit = 0; m_run = 0; m_held = 0;
    m_lp = 0; m_press = 0; m_rel = 0; m_rep = 0;
  endtask

  task automatic model_edge();
    int p;
    p = (m_s2 == 0) ? 1 : 0;
    m_s2 = m_s1;
    m_s1 = int'(button_raw);
    m_press = 0; m_rel = 0; m_rep = 0;
    if (!enable) begin
      m_commit = 0; m_run = 0; m_held = 0; m_lp = 0;
    end else if (m_commit == 0) begin
      m_run = p ? m_run + 1 : 0;
      if (m_run >= DB) begin
        m_commit = 1; m_press = 1; m_run = 0; m_held = 0; m_lp = 0;
      end
    end else begin
      if (m_run == 0 && p == 1) begin
        m_held++;
        if (m_held == LONG) m_lp = 1;
        if (m_held > LONG && ((m_held - LONG) % REP) == 0) m_rep = 1;
      end
      m_run = p ? 0 : m_run + 1;
      if (m_run >= DB) begin
        m_commit = 0; m_rel = 1; m_lp = 0; m_held = 0; m_run = 0;
      end
    end
  endtask

  task automatic cmp_outputs();
    chk_eq("btn_level",     int'(btn_level),     m_commit);
    chk_eq("press_pulse",   int'(press_pulse),   m_press);
    chk_eq("release_pulse", int'(release_pulse), m_rel);
    chk_eq("long_press",    int'(long_press),    m_lp);
    chk_eq("repeat_pulse",  int'(repeat_pulse),  m_rep);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    @(negedge clk);
    cmp_outputs();
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    model_reset();
    cmp_outputs();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int idx, lp_at, nrep, rises, seg_len;
    logic seg_lvl;

    // 1. reset
    reset_n = 1'b1; button_raw = 1'b0; enable = 1'b1;
    model_reset();
    #1 reset_n = 1'b0;
    #1 cmp_outputs();
    tick(); tick();
    button_raw = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    chk_eq("idle_level", int'(btn_level), 0);

    // 2. clean press: committed on the 6th edge after the raw change
    button_raw = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    chk_eq("press_early", int'(btn_level), 0);
    tick();
    chk_eq("press_lat_level", int'(btn_level), 1);
    chk_eq("press_lat_pulse", int'(press_pulse), 1);
    tick();
    chk_eq("press_pulse_len", int'(press_pulse), 0);

    // 4. long press and repeat, counted from the commit edge
    lp_at = -1; nrep = 0;
    for (int k = 2; k <= 50; k++) begin
      tick();
      if (long_press && lp_at < 0) lp_at = k;
      if (repeat_pulse) nrep++;
    end
    chk_eq("long_press_at", lp_at, LONG);
    chk_eq("repeat_count", nrep, 6);

    // 5. release glitch, then a real release
    button_raw = 1'b1; tick(); tick();
    button_raw = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk_eq("glitch_level", int'(btn_level), 1);
    button_raw = 1'b1;
    idx = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (release_pulse && idx < 0) idx = k;
    end
    chk_eq("release_lat", idx, 6);
    chk_eq("release_lp", int'(long_press), 0);

    // 3. bounce rejection
    rises = 0;
    button_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); rises += int'(btn_level | press_pulse); end
    button_raw = 1'b1; tick(); rises += int'(btn_level | press_pulse);
    button_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); rises += int'(btn_level | press_pulse); end
    button_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); rises += int'(btn_level | press_pulse); end
    chk_eq("bounce_rises", rises, 0);

    // 6. enable drop while pressed, then re-debounce
    button_raw = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    enable = 1'b0;
    tick();
    chk_eq("disable_level", int'(btn_level), 0);
    chk_eq("disable_rel", int'(release_pulse), 0);
    enable = 1'b1;
    idx = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (press_pulse && idx < 0) idx = k;
    end
    chk_eq("reenable_lat", idx, DB);

    // 6b. reset in the middle of press confirmation
    button_raw = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    button_raw = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset_pulse();
    idx = -1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (press_pulse && idx < 0) idx = k;
    end
    chk_eq("post_reset_lat", idx, 2 + DB);

    // Random segments: mixed bounce lengths, long holds, enable drops, rare resets.
    for (int s = 0; s < 400; s++) begin
      seg_lvl = 1'($urandom_range(0, 1));
      seg_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70))
                                            : int'($urandom_range(1, 6));
      button_raw = seg_lvl;
      if ($urandom_range(0, 39) == 0) reset_pulse();
      for (int i = 0; i < seg_len; i++) begin
        enable = ($urandom_range(0, 59) != 0);
        tick();
      end
      enable = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
